// File: rtl/mac_pkg.sv
// Shared types and constants for the matrix MAC receive path.
package mac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_SEP,
    ST_LF,
    ST_ERR
  } state_t;

  typedef enum logic [1:0] {
    ERR_BAD_N   = 2'b00,
    ERR_SEP     = 2'b01,
    ERR_UART    = 2'b10,
    ERR_TIMEOUT = 2'b11
  } err_code_t;

  localparam logic [7:0] CHAR_SP = 8'h20;
  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

endpackage

// File: rtl/mac_rx_watchdog.sv
// Inter-byte idle counter; expire is a one-cycle strobe on the stall cycle
// that reaches TIMEOUT_CYCLES. Only built when MAC_RX_TIMEOUT_EN is defined.
module mac_rx_watchdog #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic system_clock,
  input  logic rst,
  input  logic clock_enable,
  input  logic active,
  input  logic kick,
  output logic expire
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);

  logic [W-1:0] idle_cnt;

  assign expire = clock_enable && active && !kick &&
                  (idle_cnt == W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge system_clock) begin
    if (rst || !active) begin
      idle_cnt <= '0;
    end else if (clock_enable) begin
      if (kick || expire) idle_cnt <= '0;
      else                idle_cnt <= idle_cnt + W'(1);
    end
  end

endmodule

// File: rtl/mac_rx_parser.sv
// Decodes a space/CRLF formatted NxN byte matrix from the UART RX stream into
// linear-address element writes. Optional inter-byte timeout: MAC_RX_TIMEOUT_EN.
module mac_rx_parser
  import mac_pkg::*;
#(
  parameter int MAX_N          = 256,
  parameter int CNT_W          = 17,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic             system_clock,
  input  logic             rst,
  input  logic             clock_enable,
  input  logic             arm,
  input  logic [14:0]      num_bytes,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  input  logic             rx_frame_err,
  output logic             wr_en,
  output logic [CNT_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] data_counter,
  output logic [7:0]       line_counter,
  output state_t           fsm_state
);

  state_t            state;
  err_code_t         err_cause;
  logic [CNT_W-1:0]  n_reg;
  logic [CNT_W-1:0]  total;
  logic [CNT_W-1:0]  col;
  logic              accepted;
  logic              timeout_hit;
  logic              bad_n;

  assign accepted  = rx_valid && clock_enable;
  assign bad_n     = (num_bytes == '0) || (num_bytes > 15'(MAX_N));
  assign err_code  = err_cause;
  assign fsm_state = state;

`ifdef MAC_RX_TIMEOUT_EN
  mac_rx_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .system_clock (system_clock),
    .rst          (rst),
    .clock_enable (clock_enable),
    .active       (busy),
    .kick         (accepted),
    .expire       (timeout_hit)
  );
`else
  // Without the watchdog a frame may stall forever; a zero timeout never fires either.
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge system_clock) begin
    if (rst) begin
      state        <= ST_IDLE;
      err_cause    <= ERR_BAD_N;
      n_reg        <= '0;
      total        <= '0;
      col          <= '0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      data_counter <= '0;
      line_counter <= '0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      if (clock_enable) begin
        case (state)
          ST_IDLE, ST_ERR: begin
            if (arm && bad_n) begin
              err       <= 1'b1;
              err_cause <= ERR_BAD_N;
              state     <= ST_IDLE;
            end else if (arm) begin
              n_reg        <= CNT_W'(num_bytes);
              total        <= CNT_W'(num_bytes) * CNT_W'(num_bytes);
              data_counter <= '0;
              line_counter <= '0;
              col          <= '0;
              err          <= 1'b0;
              err_cause    <= ERR_BAD_N;
              busy         <= 1'b1;
              state        <= ST_DATA;
            end
          end
          default: begin
            if (timeout_hit) begin
              err       <= 1'b1;
              err_cause <= ERR_TIMEOUT;
              busy      <= 1'b0;
              state     <= ST_ERR;
            end else if (accepted && rx_frame_err) begin
              err       <= 1'b1;
              err_cause <= ERR_UART;
              busy      <= 1'b0;
              state     <= ST_ERR;
            end else if (accepted) begin
              case (state)
                ST_DATA: begin
                  // Element bytes are opaque: separator codes are legal data here.
                  wr_en        <= 1'b1;
                  wr_addr      <= data_counter;
                  wr_data      <= rx_data;
                  data_counter <= data_counter + CNT_W'(1);
                  col          <= (col == n_reg - CNT_W'(1)) ? '0 : col + CNT_W'(1);
                  if (n_reg == CNT_W'(1)) begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                  end else begin
                    state <= ST_SEP;
                  end
                end
                ST_SEP: begin
                  if (col != '0 && rx_data == CHAR_SP) begin
                    state <= ST_DATA;
                  end else if (col == '0 && rx_data == CHAR_CR) begin
                    state <= ST_LF;
                  end else begin
                    err       <= 1'b1;
                    err_cause <= ERR_SEP;
                    busy      <= 1'b0;
                    state     <= ST_ERR;
                  end
                end
                ST_LF: begin
                  if (rx_data == CHAR_LF) begin
                    line_counter <= line_counter + 8'd1;
                    if (data_counter == total) begin
                      done  <= 1'b1;
                      busy  <= 1'b0;
                      state <= ST_IDLE;
                    end else begin
                      state <= ST_DATA;
                    end
                  end else begin
                    err       <= 1'b1;
                    err_cause <= ERR_SEP;
                    busy      <= 1'b0;
                    state     <= ST_ERR;
                  end
                end
                default: state <= ST_IDLE;
              endcase
            end
          end
        endcase
      end
    end
  end

endmodule

// File: doc/mac_rx_parser.md
# mac_rx_parser

Receive-side counterpart of the matrix MAC transmitter. Consumes the byte stream delivered by the UART receiver and decodes a formatted NxN byte matrix: raw element bytes separated by 0x20, each row terminated by 0x0D 0x0A. It writes each element to a matrix buffer at its linear address, tracks row and element progress, and flags format and link errors. It sits between the UART RX core and the matrix storage RAM.

## Interface
- MAX_N, 256: largest supported matrix dimension.
- CNT_W, 17: element counter/address width; must hold MAX_N*MAX_N (65536).
- TIMEOUT_CYCLES, 100000: inter-byte timeout in enabled cycles; used only with MAC_RX_TIMEOUT_EN.

- system_clock  in  1  single clock for the whole block.
- rst  in  1  reset; synchronous, active-high.
- clock_enable  in  1  all state updates and rx_valid sampling are qualified by this input.
- arm  in  1  starts frame reception; num_bytes is sampled on the same cycle.
- num_bytes  in  15  matrix dimension N.
- rx_valid  in  1  one-cycle strobe from the UART RX core; a byte is present.
- rx_data  in  8  received byte.
- rx_frame_err  in  1  stop-bit error; qualified by rx_valid.
- wr_en  out  1  one-cycle element write strobe.
- wr_addr  out  CNT_W  linear element address, row*N+col.
- wr_data  out  8  element byte.
- busy  out  1  frame reception in progress.
- done  out  1  one-cycle pulse when the frame completes.
- err  out  1  sticky error flag; cleared by arm or rst.
- err_code  out  2  error cause, valid while err=1: 00 bad N, 01 separator mismatch, 10 UART framing, 11 timeout.
- data_counter  out  CNT_W  elements written in the current frame.
- line_counter  out  8  rows completed; 8-bit, wraps modulo 256.

## Operation
- An accepted byte means rx_valid=1 and clock_enable=1 on the same cycle. All events below trigger only on accepted bytes.
- States:
  - IDLE: waits for arm.
  - DATA: expects an element byte.
  - SEP: expects 0x20 between elements, or 0x0D after the last element of a row.
  - LF: expects 0x0A.
  - ERR: discards all bytes until arm.
- Arm handling:
  - arm in IDLE or ERR with 1 <= num_bytes <= MAX_N:
    - latch N, compute total=N*N into a CNT_W register, clear the counters, col, err and err_code, set busy, go to DATA.
  - arm with num_bytes=0 or num_bytes>MAX_N: set err=1, err_code=00, stay in IDLE.
  - arm while busy is ignored.
- DATA: the byte value is not examined (0x20, 0x0D and 0x0A are legal element values). Per accepted byte:
  - issue a write with wr_addr=data_counter, then increment data_counter.
  - if col==N-1, clear col; otherwise increment col. Go to SEP.
  - N=1 exception: the frame is a single byte with no terminator. Go to IDLE and pulse done.
- SEP: if col!=0 (mid-row), expect 0x20 and go to DATA. If col==0 (row ended), expect 0x0D and go to LF.
- LF: expect 0x0A and increment line_counter.
  - If data_counter==total, pulse done, clear busy, go to IDLE.
  - Otherwise go to DATA.
- The final row is terminated by CR LF like every other row.
- Any mismatch in SEP or LF: err=1, err_code=01, busy=0, go to ERR.
- rx_frame_err=1 on an accepted byte in DATA, SEP or LF: err=1, err_code=10, go to ERR. No write is issued for that byte.
- data_counter and line_counter hold their values after done or an error, until the next valid arm.

## Timing
- Reset values: wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, err=0, err_code=00, data_counter=0, line_counter=0; state=IDLE.
- Write latency: wr_en, wr_addr and wr_data are registered and appear exactly one cycle after the accepted byte.
- done latency: done pulses one cycle after the final LF is accepted (for N=1, after the single byte).
- busy rises the cycle after a valid arm.
- Pulse width: wr_en and done are high for exactly one system_clock cycle. When clock_enable=0 they are forced low.
- Back-to-back rx_valid on consecutive cycles must be accepted with no loss.
- rst asserted mid-frame aborts on the next edge: all outputs return to reset values and no further writes are issued.
- N=256 (MAX_N) case:
  - total=65536.
  - wr_addr reaches 65535.
  - line_counter wraps to 0 on the final LF.
  - done still asserts.

## Configuration
- MAC_RX_TIMEOUT_EN defined:
  - While busy, an idle counter increments on each enabled cycle with no accepted byte, and resets on each accepted byte.
  - On reaching TIMEOUT_CYCLES: err=1, err_code=11, go to ERR.
- MAC_RX_TIMEOUT_EN undefined: no counter is built, err_code 11 never occurs, and the block waits indefinitely.

## Structure
- Shared package mac_pkg contains:
  - the state enum typedef;
  - constants CHAR_SP=8'h20, CHAR_CR=8'h0D, CHAR_LF=8'h0A;
  - the err_code enum typedef.
- Sub-module mac_rx_watchdog holds the timeout counter and emits a one-cycle expiry. It is instantiated only under MAC_RX_TIMEOUT_EN.

## Test plan
- N=2, stream A1 20 B2 0D 0A C3 20 D4 0D 0A:
  - four writes, (0,A1) (1,B2) (2,C3) (3,D4);
  - line_counter=2;
  - done pulses once, one cycle after the last 0A;
  - err=0.
- N=2, elements 20 and 0D as data, stream 20 20 0D 0D 0A 0A 20 0A 0D 0A: writes (0,20) (1,0D) (2,0A) (3,0A), done asserts.
- N=3, stream 11 20 22 0D: err=1, err_code=01 after the 0D arrives where 0x20 is expected; no further writes; arm recovers the block.
- N=1, single byte 5A: write (0,5A), done pulses, no separators consumed.
- N=0 at arm: err_code=00, busy stays 0. Separately, rx_frame_err on the second byte: err_code=10, and only one write is issued.
- rst mid-frame after 3 bytes: all outputs return to reset values and the next arm starts cleanly. With MAC_RX_TIMEOUT_EN and TIMEOUT_CYCLES=50, stalling 50 enabled cycles gives err_code=11.
